axi4_stream_pkt_arbiter: RTL and testbench



---
 rtl/axi4_stream_arb_pkg.sv | 42 ++++
 rtl/axi4_stream_if.sv | 20 ++
 rtl/axi4_stream_pkt_arbiter_rr_arbiter.sv | 26 ++
 rtl/axi4_stream_pkt_arbiter.sv | 140 ++++++++++++++
 tb/tb_axi4_stream_pkt_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_arb_pkg.sv
// Shared types and round-robin helpers for the packet arbiter and reusable arbiters.
package axi4_stream_arb_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    // First set request searching upward from last_grant+1 with wrap; bits above
    // the real requester count are expected to be zero.
    function automatic logic [MAX_REQ-1:0] rr_select(input logic [MAX_REQ-1:0] req,
                                                     input logic [IDX_W-1:0]   last_grant);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [IDX_W-1:0]   idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            idx = last_grant + IDX_W'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned DEST_WIDTH = 1
) ();
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axi4_stream_pkt_arbiter_rr_arbiter.sv
// Round-robin pointer: combinational grant from the registered last-served index.
module rr_arbiter
    import axi4_stream_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    input  logic [N-1:0] served,
    output logic [N-1:0] grant_c
);
    logic [IDX_W-1:0] last_q;

    assign grant_c = N'(rr_select(MAX_REQ'(req), last_q));

    // Starting at N-1 makes requester 0 the first winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IDX_W'(N - 1);
        end else if (advance) begin
            last_q <= onehot_to_idx(MAX_REQ'(served));
        end
    end
endmodule

// File: rtl/axi4_stream_pkt_arbiter.sv
// Packet-granular round-robin AXI4-Stream arbiter with a registered output stage.
// Per-requester packet counters when AXI4_STREAM_PKT_ARBITER_STATS_EN is defined.
module axi4_stream_pkt_arbiter
    import axi4_stream_arb_pkg::*;
#(
    parameter int unsigned REQ_NUM    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned ID_WIDTH   = 2
`ifdef AXI4_STREAM_PKT_ARBITER_STATS_EN
    ,
    parameter int unsigned CNT_WIDTH  = 16
`endif
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [REQ_NUM-1:0]               req_tvalid_i,
    output logic [REQ_NUM-1:0]               req_tready_o,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]    req_tdata_i,
    input  logic [REQ_NUM*DATA_WIDTH/8-1:0]  req_tkeep_i,
    input  logic [REQ_NUM-1:0]               req_tlast_i,
    input  logic [REQ_NUM*USER_WIDTH-1:0]    req_tuser_i,
    axi4_stream_if.master                    pkt_o,
    output logic [REQ_NUM-1:0]               grant_o,
    output logic                             busy_o
`ifdef AXI4_STREAM_PKT_ARBITER_STATS_EN
    ,
    input  logic                             stats_clr_i,
    output logic [REQ_NUM*CNT_WIDTH-1:0]     pkt_cnt_o
`endif
);
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;
    localparam int unsigned SEL_W  = $clog2(REQ_NUM);

    state_t                 state_q, state_d;
    logic [REQ_NUM-1:0]     grant_q, grant_d, arb_grant_c;
    logic [SEL_W-1:0]       sel_idx_c;
    logic                   out_ready_c, hs_c, done_c;

    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [KEEP_W-1:0]      out_keep_q;
    logic                   out_last_q;
    logic [USER_WIDTH-1:0]  out_user_q;
    logic [ID_WIDTH-1:0]    out_id_q;

    rr_arbiter #(.N(REQ_NUM)) u_rr (
        .clk     (clk_i),
        .rst     (rst_i),
        .req     (req_tvalid_i),
        .advance (done_c),
        .served  (grant_q),
        .grant_c (arb_grant_c)
    );

    // grant_q is zero outside PKT, so tready is only ever offered to the owner.
    assign sel_idx_c    = SEL_W'(onehot_to_idx(MAX_REQ'(grant_q)));
    assign out_ready_c  = !out_valid_q || pkt_o.tready;
    assign req_tready_o = grant_q & {REQ_NUM{out_ready_c}};
    assign hs_c         = |(req_tvalid_i & req_tready_o);
    assign done_c       = hs_c && req_tlast_i[sel_idx_c];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (|req_tvalid_i) begin
                    grant_d = arb_grant_c;
                    state_d = PKT;
                end
            end
            PKT: begin
                if (done_c) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Load-and-drain in one cycle keeps the stage full for back-to-back words.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= '0;
            out_id_q    <= '0;
        end else if (hs_c) begin
            out_valid_q <= 1'b1;
            out_data_q  <= req_tdata_i[sel_idx_c*DATA_WIDTH +: DATA_WIDTH];
            out_keep_q  <= req_tkeep_i[sel_idx_c*KEEP_W +: KEEP_W];
            out_last_q  <= req_tlast_i[sel_idx_c];
            out_user_q  <= req_tuser_i[sel_idx_c*USER_WIDTH +: USER_WIDTH];
            out_id_q    <= ID_WIDTH'(sel_idx_c);
        end else if (pkt_o.tready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign pkt_o.tvalid = out_valid_q;
    assign pkt_o.tdata  = out_data_q;
    assign pkt_o.tkeep  = out_keep_q;
    assign pkt_o.tstrb  = out_keep_q;
    assign pkt_o.tlast  = out_last_q;
    assign pkt_o.tuser  = out_user_q;
    assign pkt_o.tid    = out_id_q;
    assign pkt_o.tdest  = '0;

    assign grant_o = grant_q;
    assign busy_o  = (state_q == PKT) || out_valid_q;

`ifdef AXI4_STREAM_PKT_ARBITER_STATS_EN
    logic [REQ_NUM*CNT_WIDTH-1:0] cnt_q;

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || stats_clr_i) begin
            cnt_q <= '0;
        end else if (done_c) begin
            cnt_q[sel_idx_c*CNT_WIDTH +: CNT_WIDTH] <=
                cnt_q[sel_idx_c*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
        end
    end

    assign pkt_cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// Directed bench for axi4_stream_pkt_arbiter; the stats test runs when
// AXI4_STREAM_PKT_ARBITER_STATS_EN is defined.
module tb_axi4_stream_pkt_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]      req_tvalid, req_tready, req_tlast, req_tuser, grant;
    logic [N*DW-1:0]   req_tdata;
    logic [N*DW/8-1:0] req_tkeep;
    logic              busy;
`ifdef AXI4_STREAM_PKT_ARBITER_STATS_EN
    logic              stats_clr;
    logic [N*16-1:0]   pkt_cnt;
`endif

    axi4_stream_if #(.DATA_WIDTH(DW), .USER_WIDTH(1), .ID_WIDTH(2), .DEST_WIDTH(1)) pkt_if ();

    axi4_stream_pkt_arbiter #(.REQ_NUM(N), .DATA_WIDTH(DW), .USER_WIDTH(1), .ID_WIDTH(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_tvalid_i (req_tvalid),
        .req_tready_o (req_tready),
        .req_tdata_i  (req_tdata),
        .req_tkeep_i  (req_tkeep),
        .req_tlast_i  (req_tlast),
        .req_tuser_i  (req_tuser),
        .pkt_o        (pkt_if),
        .grant_o      (grant),
        .busy_o       (busy)
`ifdef AXI4_STREAM_PKT_ARBITER_STATS_EN
        ,
        .stats_clr_i  (stats_clr),
        .pkt_cnt_o    (pkt_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int   src_left [N];
    int   src_len  [N];
    int   src_w    [N];
    int   src_seq  [N];
    logic src_hold [N];

    logic [31:0] log_data[$];
    int          log_tid[$];
    logic        log_last[$];
    int          log_cyc[$];
    logic [31:0] in_q[$];

    int exp_src[5] = '{0, 1, 2, 3, 0};
    int exp_tid4[5] = '{0, 0, 0, 2, 2};
    logic [31:0] exp_dat4[5] = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C,
                                 32'h0200_000A, 32'h0200_000B};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_val(input int k, input int seq, input int w);
        return {8'(k), 8'(seq), 16'(w + 10)};
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_tvalid[k]          = (src_left[k] > 0) && !src_hold[k];
            req_tdata[k*DW +: DW]  = word_val(k, src_seq[k], src_w[k]);
            req_tlast[k]           = (src_w[k] == src_len[k] - 1);
            req_tkeep[k*4 +: 4]    = 4'hF;
            req_tuser[k]           = k[0];
        end
    endtask

    task automatic src_clear();
        for (int k = 0; k < N; k++) begin
            src_left[k] = 0;
            src_len[k]  = 1;
            src_w[k]    = 0;
            src_seq[k]  = 0;
            src_hold[k] = 1'b0;
        end
        log_data.delete();
        log_tid.delete();
        log_last.delete();
        log_cyc.delete();
        in_q.delete();
        drive();
    endtask

    // One clock: sample handshakes mid-cycle, advance sources after the edge.
    task automatic step();
        logic [N-1:0] hs;
        logic         ohs;
        @(negedge clk);
        hs  = req_tvalid & req_tready;
        ohs = pkt_if.tvalid && pkt_if.tready;
        if (ohs) begin
            log_data.push_back(pkt_if.tdata);
            log_tid.push_back(int'(pkt_if.tid));
            log_last.push_back(pkt_if.tlast);
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (hs[k]) begin
                in_q.push_back(req_tdata[k*DW +: DW]);
                if (req_tlast[k]) begin
                    src_w[k] = 0;
                    src_seq[k]++;
                    src_left[k]--;
                end else begin
                    src_w[k]++;
                end
            end
        end
        drive();
    endtask

    function automatic bit pending();
        for (int k = 0; k < N; k++) begin
            if (src_left[k] > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic run_until_idle(input string tag, input int max_steps);
        int n = 0;
        while ((pending() || busy) && n < max_steps) begin
            step();
            n++;
        end
        check(tag, 64'(n < max_steps), 64'd1);
    endtask

    initial begin
        rst           = 1'b1;
        pkt_if.tready = 1'b1;
`ifdef AXI4_STREAM_PKT_ARBITER_STATS_EN
        stats_clr     = 1'b0;
`endif
        src_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant",  64'(grant),         64'd0);
        check("rst_busy",   64'(busy),          64'd0);
        check("rst_tvalid", 64'(pkt_if.tvalid), 64'd0);
        check("rst_tready", 64'(req_tready),    64'd0);
        check("rst_tdata",  64'(pkt_if.tdata),  64'd0);
        rst = 1'b0;

        // Single requester, 3-word packet
        src_len[1] = 3; src_left[1] = 1; drive();
        step();
        check("t1_grant",  64'(grant),         64'(4'b0010));
        check("t1_rdy",    64'(req_tready),    64'(4'b0010));
        check("t1_vld0",   64'(pkt_if.tvalid), 64'd0);
        step();
        check("t1_vldA",   64'(pkt_if.tvalid), 64'd1);
        check("t1_dataA",  64'(pkt_if.tdata),  64'h0100_000A);
        check("t1_tid",    64'(pkt_if.tid),    64'd1);
        check("t1_lastA",  64'(pkt_if.tlast),  64'd0);
        check("t1_user",   64'(pkt_if.tuser),  64'd1);
        check("t1_strb",   64'(pkt_if.tstrb),  64'hF);
        check("t1_dest",   64'(pkt_if.tdest),  64'd0);
        step();
        check("t1_dataB",  64'(pkt_if.tdata),  64'h0100_000B);
        step();
        check("t1_dataC",  64'(pkt_if.tdata),  64'h0100_000C);
        check("t1_lastC",  64'(pkt_if.tlast),  64'd1);
        check("t1_gnt0",   64'(grant),         64'd0);
        check("t1_busy",   64'(busy),          64'd1);
        step();
        check("t1_drain",  64'(pkt_if.tvalid), 64'd0);
        check("t1_idle",   64'(busy),          64'd0);

        // Reset in the middle of a 4-word packet
        src_clear();
        src_len[2] = 4; src_left[2] = 1; drive();
        step();
        check("t5_grant",  64'(grant), 64'(4'b0100));
        step();
        step();
        rst = 1'b1;
        step();
        check("t5_grant0", 64'(grant),         64'd0);
        check("t5_vld0",   64'(pkt_if.tvalid), 64'd0);
        check("t5_busy0",  64'(busy),          64'd0);
        check("t5_data0",  64'(pkt_if.tdata),  64'd0);
        rst = 1'b0;
        src_clear();

        // All four hold 2-word packets; fresh pointer starts at requester 0
        for (int k = 0; k < N; k++) begin
            src_len[k] = 2; src_left[k] = 3;
        end
        drive();
        run_until_idle("t2_timeout", 200);
        check("t2_count", 64'(log_data.size()), 64'd24);
        if (log_data.size() == 24) begin
            for (int p = 0; p < 5; p++) begin
                check($sformatf("t2_src%0d", p), 64'(log_tid[2*p]), 64'(exp_src[p]));
                check($sformatf("t2_pair%0d", p), 64'(log_cyc[2*p+1] - log_cyc[2*p]), 64'd1);
            end
            for (int p = 1; p < 5; p++) begin
                check($sformatf("t2_gap%0d", p), 64'(log_cyc[2*p] - log_cyc[2*p-1]), 64'd2);
            end
            for (int i = 0; i < 24; i++) begin
                check($sformatf("t2_data%0d", i), 64'(log_data[i]),
                      64'(word_val((i / 2) % 4, i / 8, i % 2)));
                check($sformatf("t2_last%0d", i), 64'(log_last[i]), 64'(i % 2 == 1));
            end
        end

        // Backpressure for 5 cycles mid-packet
        src_clear();
        src_len[1] = 4; src_left[1] = 1; drive();
        step();
        step();
        pkt_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t3_vld%0d", i),  64'(pkt_if.tvalid), 64'd1);
            check($sformatf("t3_hold%0d", i), 64'(pkt_if.tdata),  64'h0100_000A);
            check($sformatf("t3_rdy%0d", i),  64'(req_tready),    64'd0);
        end
        pkt_if.tready = 1'b1;
        run_until_idle("t3_timeout", 50);
        check("t3_count", 64'(log_data.size()), 64'd4);
        check("t3_inq",   64'(in_q.size()),     64'd4);
        if (log_data.size() == 4 && in_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t3_data%0d", i), 64'(log_data[i]), 64'(32'h0100_000A + 32'(i)));
                check($sformatf("t3_sb%0d", i),   64'(log_data[i]), 64'(in_q[i]));
            end
        end

        // Granted requester stalls while requester 2 waits
        src_clear();
        src_len[0] = 3; src_left[0] = 1; drive();
        step();
        check("t4_grant", 64'(grant), 64'(4'b0001));
        src_len[2] = 2; src_left[2] = 1; drive();
        step();
        src_hold[0] = 1'b1; drive();
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t4_held%0d", i), 64'(grant),      64'(4'b0001));
            check($sformatf("t4_rdy%0d", i),  64'(req_tready), 64'(4'b0001));
        end
        src_hold[0] = 1'b0; drive();
        run_until_idle("t4_timeout", 50);
        check("t4_count", 64'(log_data.size()), 64'd5);
        if (log_data.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("t4_tid%0d", i),  64'(log_tid[i]),  64'(exp_tid4[i]));
                check($sformatf("t4_data%0d", i), 64'(log_data[i]), 64'(exp_dat4[i]));
            end
        end

        // Single-word packet holds PKT for exactly one cycle
        src_clear();
        src_len[3] = 1; src_left[3] = 1; drive();
        step();
        check("t6_grant",  64'(grant), 64'(4'b1000));
        step();
        check("t6_gnt0",   64'(grant),         64'd0);
        check("t6_vld",    64'(pkt_if.tvalid), 64'd1);
        check("t6_last",   64'(pkt_if.tlast),  64'd1);
        check("t6_tid",    64'(pkt_if.tid),    64'd3);
        run_until_idle("t6_timeout", 20);

`ifdef AXI4_STREAM_PKT_ARBITER_STATS_EN
        // Counter 3: five packets, then clear coincident with a sixth tlast
        src_clear();
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        src_len[3] = 1; src_left[3] = 5; drive();
        run_until_idle("st_timeout", 100);
        check("st_cnt5", 64'(pkt_cnt[3*16 +: 16]), 64'd5);
        check("st_cnt0", 64'(pkt_cnt[0 +: 16]),    64'd0);
        src_left[3] = 1; drive();
        step();
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check("st_hs",   64'(src_left[3]),         64'd0);
        check("st_clr",  64'(pkt_cnt[3*16 +: 16]), 64'd0);
        run_until_idle("st_timeout2", 20);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
